// File: rtl/stoch_signed_decoder_array_pkg.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stoch_decode_pkg: shared state type and helpers for the signed decoder.   |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
package stoch_decode_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Extra two bits hold the sign and the +N extreme of the range.
   function automatic int y_width(input int window_log2);
      return window_log2 + 2;
   endfunction

   localparam int DEFAULT_WINDOW_LOG2 = 8;

   typedef logic signed [y_width(DEFAULT_WINDOW_LOG2)-1:0] y_elem_t;

   function automatic logic signed [1:0] stoch_delta(input logic p, input logic m);
      return $signed({1'b0, p}) - $signed({1'b0, m});
   endfunction

endpackage
`default_nettype wire

// File: rtl/stoch_signed_counter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stoch_signed_counter: up/down accumulator for one p/m stream pair.        |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module stoch_signed_counter
   import stoch_decode_pkg::*;
#(
   parameter int Y_WIDTH = 10
) (
   input  logic                      CLK,
   input  logic                      nRST,
   input  logic                      clr,
   input  logic                      en,
   input  logic                      p,
   input  logic                      m,
   output logic signed [Y_WIDTH-1:0] count
);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + Y_WIDTH'(stoch_delta(p, m));
      end
   end

endmodule
`default_nettype wire

// File: rtl/stoch_signed_decoder_array.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stoch_signed_decoder_array: windowed decode of signed stochastic streams. |
// | Optional abort input under macro STOCH_DECODE_ABORT_EN.  Rev 1.0           |
// +---------------------------------------------------------------------------+
module stoch_signed_decoder_array
   import stoch_decode_pkg::*;
#(
   parameter int  NUM_ELEMS   = 16,
   parameter int  WINDOW_LOG2 = 8,
   localparam int Y_WIDTH     = y_width(WINDOW_LOG2)
) (
   input  logic                              CLK,
   input  logic                              nRST,
   input  logic                              start,
`ifdef STOCH_DECODE_ABORT_EN
   input  logic                              abort,
`endif
   input  logic [NUM_ELEMS-1:0]              x_p,
   input  logic [NUM_ELEMS-1:0]              x_m,
   output logic                              busy,
   output logic                              y_valid,
   input  logic                              y_ready,
   output logic [NUM_ELEMS-1:0][Y_WIDTH-1:0] y
);

   state_t                 state;
   state_t                 state_next;
   logic [WINDOW_LOG2-1:0] sample_cnt;
   logic                   clr;
   logic                   acc_en;
   logic                   capture;
   logic                   abort_req;
   logic                   window_last;

`ifdef STOCH_DECODE_ABORT_EN
   assign abort_req = abort;
`else
   assign abort_req = 1'b0;
`endif

   assign window_last = (sample_cnt == {WINDOW_LOG2{1'b1}});
   assign busy        = (state == ACCUM);
   assign y_valid     = (state == HOLD);

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      clr        = 1'b0;
      acc_en     = 1'b0;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               clr        = 1'b1;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            acc_en = 1'b1;
            if (window_last) begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (y_ready) begin
               if (start) begin
                  clr        = 1'b1;
                  state_next = ACCUM;
               end else begin
                  state_next = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase
      // Abort overrides every other exit; the result register is left alone.
      if (abort_req && (state != IDLE)) begin
         state_next = IDLE;
         clr        = 1'b1;
         acc_en     = 1'b0;
         capture    = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         sample_cnt <= '0;
      end else if (clr) begin
         sample_cnt <= '0;
      end else if (acc_en) begin
         sample_cnt <= sample_cnt + 1'b1;
      end
   end

   for (genvar e = 0; e < NUM_ELEMS; e++) begin : g_elem
      logic signed [Y_WIDTH-1:0] count;
      logic signed [Y_WIDTH-1:0] sum_final;
      logic        [Y_WIDTH-1:0] result;

      stoch_signed_counter #(
         .Y_WIDTH (Y_WIDTH)
      ) u_cnt (
         .CLK   (CLK),
         .nRST  (nRST),
         .clr   (clr),
         .en    (acc_en),
         .p     (x_p[e]),
         .m     (x_m[e]),
         .count (count)
      );

      // The last sample lands on the capture edge, so fold it in here.
      assign sum_final = count + Y_WIDTH'(stoch_delta(x_p[e], x_m[e]));

      always_ff @(posedge CLK or negedge nRST) begin
         if (!nRST) begin
            result <= '0;
         end else if (capture) begin
            result <= sum_final;
         end
      end

      assign y[e] = result;
   end

endmodule
`default_nettype wire

// File: tb/tb_stoch_signed_decoder_array.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_stoch_signed_decoder_array: directed bench, NUM_ELEMS=4, WINDOW_LOG2=4. |
// | Rev 1.0                                                                   |
// +---------------------------------------------------------------------------+
module tb_stoch_signed_decoder_array;

   localparam int NE = 4;
   localparam int WL = 4;
   localparam int N  = 16;
   localparam int YW = WL + 2;

   logic               CLK = 1'b0;
   logic               nRST = 1'b0;
   logic               start = 1'b0;
   logic [NE-1:0]      x_p = '0;
   logic [NE-1:0]      x_m = '0;
   logic               busy;
   logic               y_valid;
   logic               y_ready = 1'b0;
   logic [NE-1:0][YW-1:0] y;
   logic [NE-1:0][YW-1:0] exp_y;
   logic [NE-1:0][YW-1:0] held_y;
`ifdef STOCH_DECODE_ABORT_EN
   logic               abort = 1'b0;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   stoch_signed_decoder_array #(
      .NUM_ELEMS   (NE),
      .WINDOW_LOG2 (WL)
   ) dut (
      .CLK     (CLK),
      .nRST    (nRST),
      .start   (start),
`ifdef STOCH_DECODE_ABORT_EN
      .abort   (abort),
`endif
      .x_p     (x_p),
      .x_m     (x_m),
      .busy    (busy),
      .y_valid (y_valid),
      .y_ready (y_ready),
      .y       (y)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic begin_window();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++;
      if (y_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", y_valid); else pass_cnt++;
      total_cnt++;
      if (y !== '0) $display("FAIL reset_y: got %h want 0", y); else pass_cnt++;
      step();
      step();
      nRST = 1'b1;
      step();
   endtask

   task automatic test_constant_rails();
      begin_window();
      x_p = 4'b0101;
      x_m = 4'b0110;
      for (int i = 0; i < N; i++) begin
         step();
         if (i == 0) begin
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL const_busy: got %b want 1", busy); else pass_cnt++;
         end
         if (i == N - 2) begin
            total_cnt++;
            if (y_valid !== 1'b0) $display("FAIL const_early_valid: got %b want 0", y_valid); else pass_cnt++;
         end
      end
      exp_y[0] = 6'd16;
      exp_y[1] = -6'sd16;
      exp_y[2] = 6'd0;
      exp_y[3] = 6'd0;
      total_cnt++;
      if (y_valid !== 1'b1) $display("FAIL const_valid: got %b want 1", y_valid); else pass_cnt++;
      total_cnt++;
      if (busy !== 1'b0) $display("FAIL const_busy_hold: got %b want 0", busy); else pass_cnt++;
      total_cnt++;
      if (y !== exp_y) $display("FAIL const_y: got %h want %h", y, exp_y); else pass_cnt++;
      y_ready = 1'b1;
      step();
      y_ready = 1'b0;
      total_cnt++;
      if (y_valid !== 1'b0) $display("FAIL const_after_xfer_valid: got %b want 0", y_valid); else pass_cnt++;
      total_cnt++;
      if (y !== exp_y) $display("FAIL const_y_retained: got %h want %h", y, exp_y); else pass_cnt++;
   endtask

   task automatic test_patterns();
      begin_window();
      for (int i = 0; i < N; i++) begin
         x_p[0] = (i % 2 == 0);
         x_m[0] = 1'b0;
         x_p[1] = (i < 12);
         x_m[1] = (i >= 12);
         x_p[2] = (i < 5);
         x_m[2] = 1'b0;
         x_p[3] = 1'b0;
         x_m[3] = (i % 3 == 0);
         step();
      end
      exp_y[0] = 6'd8;
      exp_y[1] = 6'd8;
      exp_y[2] = 6'd5;
      exp_y[3] = -6'sd6;
      total_cnt++;
      if (y_valid !== 1'b1) $display("FAIL pat_valid: got %b want 1", y_valid); else pass_cnt++;
      total_cnt++;
      if (y !== exp_y) $display("FAIL pat_y: got %h want %h", y, exp_y); else pass_cnt++;
   endtask

   // Continues from the HOLD state left by test_patterns.
   task automatic test_back_to_back();
      held_y = exp_y;
      for (int i = 0; i < 20; i++) begin
         x_p   = 4'($urandom);
         x_m   = 4'($urandom);
         start = (i % 2 == 0);
         step();
         total_cnt++;
         if (y !== held_y) $display("FAIL hold_y[%0d]: got %h want %h", i, y, held_y); else pass_cnt++;
         total_cnt++;
         if (y_valid !== 1'b1 || busy !== 1'b0)
            $display("FAIL hold_flags[%0d]: got valid=%b busy=%b want valid=1 busy=0", i, y_valid, busy);
         else pass_cnt++;
      end
      y_ready = 1'b1;
      start   = 1'b1;
      x_p     = 4'b0000;
      x_m     = 4'b1111;
      step();
      y_ready = 1'b0;
      start   = 1'b0;
      total_cnt++;
      if (busy !== 1'b1 || y_valid !== 1'b0)
         $display("FAIL b2b_restart: got busy=%b valid=%b want busy=1 valid=0", busy, y_valid);
      else pass_cnt++;
      x_p = 4'b1111;
      x_m = 4'b0000;
      for (int i = 0; i < N; i++) begin
         step();
         if (i == N - 2) begin
            total_cnt++;
            if (y_valid !== 1'b0) $display("FAIL b2b_early_valid: got %b want 0", y_valid); else pass_cnt++;
         end
      end
      exp_y = {4{6'd16}};
      total_cnt++;
      if (y_valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", y_valid); else pass_cnt++;
      total_cnt++;
      if (y !== exp_y) $display("FAIL b2b_y: got %h want %h", y, exp_y); else pass_cnt++;
      y_ready = 1'b1;
      step();
      y_ready = 1'b0;
   endtask

   task automatic test_start_ignored();
      begin_window();
      x_p = 4'b0011;
      x_m = 4'b1000;
      for (int i = 0; i < N; i++) begin
         start = (i == 3 || i == 10);
         step();
         if (i == N - 2) begin
            total_cnt++;
            if (y_valid !== 1'b0) $display("FAIL ign_early_valid: got %b want 0", y_valid); else pass_cnt++;
         end
      end
      start = 1'b0;
      exp_y[0] = 6'd16;
      exp_y[1] = 6'd16;
      exp_y[2] = 6'd0;
      exp_y[3] = -6'sd16;
      total_cnt++;
      if (y_valid !== 1'b1) $display("FAIL ign_valid: got %b want 1", y_valid); else pass_cnt++;
      total_cnt++;
      if (y !== exp_y) $display("FAIL ign_y: got %h want %h", y, exp_y); else pass_cnt++;
      y_ready = 1'b1;
      step();
      y_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      begin_window();
      x_p = 4'b1111;
      x_m = 4'b0000;
      for (int i = 0; i < 7; i++) step();
      #2;
      nRST = 1'b0;
      #1;
      total_cnt++;
      if (y_valid !== 1'b0 || busy !== 1'b0)
         $display("FAIL arst_flags: got valid=%b busy=%b want 0 0", y_valid, busy);
      else pass_cnt++;
      total_cnt++;
      if (y !== '0) $display("FAIL arst_y: got %h want 0", y); else pass_cnt++;
      step();
      nRST = 1'b1;
      for (int i = 0; i < N + 2; i++) step();
      total_cnt++;
      if (y_valid !== 1'b0) $display("FAIL arst_no_valid: got %b want 0", y_valid); else pass_cnt++;
      begin_window();
      x_p = 4'b1000;
      x_m = 4'b0000;
      for (int i = 0; i < N; i++) step();
      exp_y[0] = 6'd0;
      exp_y[1] = 6'd0;
      exp_y[2] = 6'd0;
      exp_y[3] = 6'd16;
      total_cnt++;
      if (y_valid !== 1'b1 || y !== exp_y)
         $display("FAIL arst_fresh: got valid=%b y=%h want valid=1 y=%h", y_valid, y, exp_y);
      else pass_cnt++;
      y_ready = 1'b1;
      step();
      y_ready = 1'b0;
   endtask

`ifdef STOCH_DECODE_ABORT_EN
   task automatic test_abort();
      held_y = y;
      begin_window();
      x_p = 4'b0001;
      x_m = 4'b0000;
      for (int i = 0; i < 5; i++) step();
      abort = 1'b1;
      step();
      abort = 1'b0;
      total_cnt++;
      if (busy !== 1'b0 || y_valid !== 1'b0)
         $display("FAIL abort_accum: got busy=%b valid=%b want 0 0", busy, y_valid);
      else pass_cnt++;
      for (int i = 0; i < N + 2; i++) step();
      total_cnt++;
      if (y_valid !== 1'b0 || y !== held_y)
         $display("FAIL abort_accum_quiet: got valid=%b y=%h want 0 %h", y_valid, y, held_y);
      else pass_cnt++;
      begin_window();
      x_p = 4'b0110;
      for (int i = 0; i < N; i++) step();
      exp_y[0] = 6'd0;
      exp_y[1] = 6'd16;
      exp_y[2] = 6'd16;
      exp_y[3] = 6'd0;
      abort   = 1'b1;
      y_ready = 1'b1;
      start   = 1'b1;
      step();
      abort   = 1'b0;
      y_ready = 1'b0;
      start   = 1'b0;
      total_cnt++;
      if (y_valid !== 1'b0 || busy !== 1'b0 || y !== exp_y)
         $display("FAIL abort_hold: got valid=%b busy=%b y=%h want 0 0 %h", y_valid, busy, y, exp_y);
      else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_constant_rails();
      test_patterns();
      test_back_to_back();
      test_start_ignored();
      test_async_reset();
`ifdef STOCH_DECODE_ABORT_EN
      test_abort();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/stoch_signed_decoder_array.md
Name: stoch_signed_decoder_array

Overview:
Converts an array of signed stochastic bitstreams (p/m rail pairs) back to binary signed integers. Each element is accumulated over a fixed window of 2^WINDOW_LOG2 clock cycles. Sits at the output end of the stochastic datapath, e.g. after the signed max-pool or conv layers, and feeds results to binary logic or a host readout. One window per start request; results are held under a valid/ready handshake.

Parameters:
NUM_ELEMS, 16, number of independent p/m stream pairs decoded in parallel
WINDOW_LOG2, 8, log2 of samples per window; N = 2^WINDOW_LOG2
Y_WIDTH, WINDOW_LOG2+2 (localparam, not overridable), signed result width; covers the range -N..+N

Ports:
CLK  input  1  clock, all state on rising edge
nRST  input  1  asynchronous active-low reset
start  input  1  request a new decode window
x_p  input  [NUM_ELEMS-1:0]  positive-rail bits, one per element
x_m  input  [NUM_ELEMS-1:0]  negative-rail bits, one per element
busy  output  1  high while a window is accumulating
y_valid  output  1  results available on y
y_ready  input  1  consumer accepts y
y  output  [NUM_ELEMS-1:0][Y_WIDTH-1:0]  signed two's-complement sums; value estimate = y / N

Behaviour:
- FSM states: IDLE, ACCUM, HOLD. A sample counter of WINDOW_LOG2 bits runs alongside the FSM.
- Reset is asynchronous. It forces: state IDLE, busy=0, y_valid=0, y=all zeros, sample counter=0, accumulators=0. Reset mid-window discards the partial sums; no y_valid follows.
- IDLE:
  - start=1 clears all accumulators and the sample counter, then moves to ACCUM.
  - Inputs on the start cycle are not sampled.
- ACCUM, busy=1:
  - Each cycle, every element e adds d = x_p[e] - x_m[e], where d is in {-1, 0, +1}.
  - p=m=1 and p=m=0 both add 0.
  - The sample counter increments each cycle. After exactly N samples (counter wraps from N-1 to 0), the FSM moves to HOLD.
  - start is ignored while in ACCUM.
  - Overflow cannot occur: |sum| <= N fits in Y_WIDTH signed bits.
- Timing: start accepted at cycle t -> samples taken at t+1..t+N -> y_valid=1 and y stable from cycle t+N+1.
- HOLD:
  - y_valid=1 and busy=0; y stays stable until the transfer.
  - y_valid & y_ready completes the transfer.
  - If start is also 1 in that cycle -> ACCUM immediately with cleared accumulators (back-to-back windows, no IDLE bubble). Otherwise -> IDLE.
  - start without y_ready is ignored; results are never overwritten while unaccepted.
  - y_ready is ignored outside HOLD.
- y is driven from a registered result copy taken at the ACCUM->HOLD transition. y keeps its last value after the handshake, until the next window completes. Zero only after reset.
- x_p and x_m are assumed synchronous to CLK. No input registering; the adder is combinational into the accumulator.

Optional Feature:
Macro STOCH_DECODE_ABORT_EN.
- Defined:
  - An extra input port abort (1 bit) is present.
  - abort=1 in ACCUM or HOLD -> IDLE on the next edge, with y_valid=0 and accumulators cleared. y keeps its previous registered value.
  - abort has priority over start, y_ready and window completion.
  - abort in IDLE has no effect.
- Not defined: the abort port does not exist, and the only exits from ACCUM and HOLD are as described above.

Decomposition:
- Package stoch_decode_pkg holds:
  - the state enum typedef (IDLE, ACCUM, HOLD);
  - a function returning Y_WIDTH from WINDOW_LOG2;
  - the signed result element typedef, parameterised through the width function.
- Sub-module stoch_signed_counter handles one element. Its ports are CLK, nRST, clr, en, p, m and a Y_WIDTH-bit signed count. It is generated NUM_ELEMS times. The top level owns the FSM, the sample counter and the result register.

Test Plan:
- WINDOW_LOG2=4, NUM_ELEMS=4; elem0 p=1,m=0 all window; elem1 p=0,m=1; elem2 p=m=1; elem3 p=m=0 -> y_valid at t+17; y={+16,-16,0,0}.
- elem0 p alternating 1/0 starting with 1, m=0 -> y[0]=+8. elem1 p=1 for 12 cycles then m=1 for 4 cycles -> y[1]=+8.
- Hold y_ready=0 for 20 cycles after y_valid, toggling the inputs and pulsing start -> y unchanged, y_valid stays 1, busy stays 0. Then y_ready=1 with start=1 -> next cycle busy=1; the new window's y_valid arrives exactly N+1 cycles after the handshake cycle.
- Assert nRST low asynchronously at sample 7 of a window -> immediately y_valid=0, busy=0, y=0. After release, start gives a fresh result with no carry-over.
- start pulsed at samples 3 and 10 during ACCUM -> ignored; y_valid at t+N+1 from the original start only.
- With STOCH_DECODE_ABORT_EN: abort at sample 5 -> IDLE next cycle with no y_valid. Abort in HOLD with y_ready=1 -> y_valid drops and the previous y is retained.
